// File: rtl/ppa_pkg.sv
// Shared definitions for the pipelined parallel-prefix adder/subtractor:
// operation encoding, ceil-log2 and the accept-to-valid latency helper.
package ppa_pkg;

    typedef enum logic {
        PPA_ADD = 1'b0,
        PPA_SUB = 1'b1
    } ppa_op_e;

    // Smallest r with 2^r >= n (n >= 1).
    function automatic int ppa_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // One register for the bitwise g/p stage, then one per group of
    // pipe_every prefix levels; the last group also produces the sum.
    function automatic int ppa_lat(input int w, input int pipe_every);
        int l;
        l = ppa_clog2(w);
        return 1 + (l + pipe_every - 1) / pipe_every;
    endfunction

endpackage

// File: rtl/ppa_prefix_level.sv
// One combinational Sklansky prefix level over a power-of-two wide g/p vector.
// At level LEVEL, every position whose bit LEVEL is set absorbs the group
// ending just below its 2^(LEVEL+1)-aligned half; all others pass through.
module ppa_prefix_level #(
    parameter int W     = 8,
    parameter int LEVEL = 0
) (
    input  logic [W-1:0] i_g,
    input  logic [W-1:0] i_p,
    output logic [W-1:0] o_g,
    output logic [W-1:0] o_p
);

    // Per-bit group combine or pass-through.
    for (genvar i = 0; i < W; i++) begin : g_bit
        if (((i >> LEVEL) & 1) == 1) begin : g_comb
            localparam int J = ((i >> (LEVEL + 1)) << (LEVEL + 1)) + (1 << LEVEL) - 1;
            assign o_g[i] = i_g[i] | (i_p[i] & i_g[J]);
            assign o_p[i] = i_p[i] & i_p[J];
        end else begin : g_pass
            assign o_g[i] = i_g[i];
            assign o_p[i] = i_p[i];
        end
    end

endmodule

// File: rtl/ppa_addsub_pipe.sv
// Pipelined Sklansky adder/subtractor with valid/ready handshake and tag.
// {out_carry, out_sum} = in_a + (in_op ? ~in_b : in_b) + in_cin.
// Optional feature: define PPA_OVF_FLAG_EN to add out_ovf (signed overflow).
module ppa_addsub_pipe
    import ppa_pkg::*;
#(
    parameter int W          = 8,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_carry,
`ifdef PPA_OVF_FLAG_EN
    output logic             out_ovf,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam int L   = ppa_clog2(W);
    localparam int NP  = 1 << L;
    localparam int LAT = ppa_lat(W, PIPE_EVERY);
    localparam int NS  = LAT - 1;   // index of the final (sum) stage

    logic [NS:0]                 r_v;
    logic [NS:0]                 w_rdy;
    logic [NS:0]                 w_vprev;
    logic [NS:0]                 w_ld;

    logic [W-1:0]                w_bx;
    logic [W-1:0]                w_x_in;
    logic [NP-1:0]               w_g_in;
    logic [NP-1:0]               w_p_in;

    logic [NS-1:0][NP-1:0]       r_g;
    logic [NS-1:0][NP-1:0]       r_p;
    logic [NS-1:0][W-1:0]        r_x;
    logic [NS-1:0][TAG_W-1:0]    r_tag;

    logic [NS-1:0][NP-1:0]       w_stg_g;
    logic [NS-1:0][NP-1:0]       w_stg_p;
    logic [NS-1:0][W-1:0]        w_stg_x;
    logic [NS-1:0][TAG_W-1:0]    w_stg_tag;

    logic [NP-1:0]               w_gf;
    logic [W-1:0]                w_sum_nx;
    logic [W-1:0]                r_sum;
    logic                        r_carry;
    logic [TAG_W-1:0]            r_tag_out;
    logic                        w_unused_lvl;

    // Bitwise generate/propagate; carry-in is folded into bit 0 so the
    // prefix tree needs no external carry and bit 0's group propagate is 0.
    always_comb begin
        w_bx      = (ppa_op_e'(in_op) == PPA_SUB) ? ~in_b : in_b;
        w_g_in    = '0;
        w_p_in    = '0;
        w_g_in[W-1:0] = in_a & w_bx;
        w_p_in[W-1:0] = in_a ^ w_bx;
        w_x_in    = in_a ^ w_bx;
        w_g_in[0] = (in_a[0] & w_bx[0]) | ((in_a[0] ^ w_bx[0]) & in_cin);
        w_p_in[0] = 1'b0;
        w_x_in[0] = in_a[0] ^ w_bx[0] ^ in_cin;
    end

    // Backpressure chain: a stage can take new data if empty or draining.
    always_comb begin
        logic c_rdy;
        w_rdy = '0;
        c_rdy = out_ready;
        for (int i = NS; i >= 0; i--) begin
            c_rdy    = ~r_v[i] | c_rdy;
            w_rdy[i] = c_rdy;
        end
    end

    assign w_vprev  = {r_v[NS-1:0], in_valid};
    assign w_ld     = w_rdy & w_vprev;
    assign in_ready = w_rdy[0];

    // Valid bits: a ready stage takes its predecessor's valid, else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
        end else begin
            r_v <= (w_rdy & w_vprev) | (~w_rdy & r_v);
        end
    end

    // Prefix levels; level l starts from a register whenever l is a cut point.
    for (genvar l = 0; l < L; l++) begin : g_lvl
        logic [NP-1:0] w_g_i;
        logic [NP-1:0] w_p_i;
        logic [NP-1:0] w_g_o;
        logic [NP-1:0] w_p_o;
        if ((l % PIPE_EVERY) == 0) begin : g_cut
            assign w_g_i = r_g[l / PIPE_EVERY];
            assign w_p_i = r_p[l / PIPE_EVERY];
        end else begin : g_chain
            assign w_g_i = g_lvl[l-1].w_g_o;
            assign w_p_i = g_lvl[l-1].w_p_o;
        end
        ppa_prefix_level #(
            .W     (NP),
            .LEVEL (l)
        ) u_level (
            .i_g (w_g_i),
            .i_p (w_p_i),
            .o_g (w_g_o),
            .o_p (w_p_o)
        );
    end

    assign w_stg_g[0]   = w_g_in;
    assign w_stg_p[0]   = w_p_in;
    assign w_stg_x[0]   = w_x_in;
    assign w_stg_tag[0] = in_tag;

    // Inputs of intermediate stages: output of the last level of the group.
    for (genvar s = 1; s < NS; s++) begin : g_stg
        assign w_stg_g[s]   = g_lvl[s*PIPE_EVERY-1].w_g_o;
        assign w_stg_p[s]   = g_lvl[s*PIPE_EVERY-1].w_p_o;
        assign w_stg_x[s]   = r_x[s-1];
        assign w_stg_tag[s] = r_tag[s-1];
    end

    // After the last level every w_gf[i] is the carry out of bit i.
    assign w_gf         = g_lvl[L-1].w_g_o;
    assign w_sum_nx     = r_x[NS-1] ^ {w_gf[W-2:0], 1'b0};
    assign w_unused_lvl = ^{g_lvl[L-1].w_p_o, w_gf};

    // Datapath registers, loaded only when the stage accepts a valid op.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            if (w_ld[s]) begin
                r_g[s]   <= w_stg_g[s];
                r_p[s]   <= w_stg_p[s];
                r_x[s]   <= w_stg_x[s];
                r_tag[s] <= w_stg_tag[s];
            end
        end
        if (w_ld[NS]) begin
            r_sum     <= w_sum_nx;
            r_carry   <= w_gf[W-1];
            r_tag_out <= r_tag[NS-1];
        end
    end

`ifdef PPA_OVF_FLAG_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (w_ld[NS]) begin
            r_ovf <= w_gf[W-1] ^ w_gf[W-2];
        end
    end

    assign out_ovf = r_v[NS] & r_ovf;
`endif

    // Data registers are unreset, so outputs read zero whenever empty.
    assign out_valid = r_v[NS];
    assign out_sum   = r_v[NS] ? r_sum     : '0;
    assign out_carry = r_v[NS] & r_carry;
    assign out_tag   = r_v[NS] ? r_tag_out : '0;

endmodule

// File: tb/tb_ppa_addsub_pipe.sv
// Bench for ppa_addsub_pipe: an 8-bit / 2-levels-per-stage instance and a
// 13-bit / 1-level-per-stage instance, checked against an arithmetic model.
module tb_ppa_addsub_pipe;
    import ppa_pkg::*;

    localparam int WA = 8;
    localparam int PA = 2;
    localparam int WB = 13;
    localparam int PB = 1;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          a_in_valid, a_in_ready, a_in_op, a_in_cin;
    logic [WA-1:0] a_in_a, a_in_b, a_out_sum;
    logic [TW-1:0] a_in_tag, a_out_tag;
    logic          a_out_valid, a_out_ready, a_out_carry;

    logic          b_in_valid, b_in_ready, b_in_op, b_in_cin;
    logic [WB-1:0] b_in_a, b_in_b, b_out_sum;
    logic [TW-1:0] b_in_tag, b_out_tag;
    logic          b_out_valid, b_out_ready, b_out_carry;

`ifdef PPA_OVF_FLAG_EN
    logic a_out_ovf, b_out_ovf, a_last_ovf;
`endif

    ppa_addsub_pipe #(.W(WA), .PIPE_EVERY(PA), .TAG_W(TW)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_op     (a_in_op),
        .in_a      (a_in_a),
        .in_b      (a_in_b),
        .in_cin    (a_in_cin),
        .in_tag    (a_in_tag),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum),
        .out_carry (a_out_carry),
`ifdef PPA_OVF_FLAG_EN
        .out_ovf   (a_out_ovf),
`endif
        .out_tag   (a_out_tag)
    );

    ppa_addsub_pipe #(.W(WB), .PIPE_EVERY(PB), .TAG_W(TW)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_op     (b_in_op),
        .in_a      (b_in_a),
        .in_b      (b_in_b),
        .in_cin    (b_in_cin),
        .in_tag    (b_in_tag),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_carry (b_out_carry),
`ifdef PPA_OVF_FLAG_EN
        .out_ovf   (b_out_ovf),
`endif
        .out_tag   (b_out_tag)
    );

    typedef struct {
        logic [15:0]   sum;
        logic          carry;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int a_nin = 0, a_nout = 0, b_nin = 0, b_nout = 0;
    int a_first_in = -1, a_first_out = -1, a_last_out = -1;
    int b_first_in = -1, b_first_out = -1;

    // Plain integer arithmetic: w-bit add of a, (optionally inverted) b, cin.
    function automatic exp_t model(input int w, input logic op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin,
                                   input logic [TW-1:0] tag);
        exp_t   e;
        longint mask, av, bv, tot, sa, sb, st, half;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        av    = longint'(a) & mask;
        bv    = op ? (~longint'(b)) & mask : longint'(b) & mask;
        tot   = av + bv + longint'(cin);
        e.sum   = 16'(tot & mask);
        e.carry = ((tot >> w) & 1) != 0;
        sa = (av >= half) ? av - (mask + 1) : av;
        sb = (bv >= half) ? bv - (mask + 1) : bv;
        st = sa + sb + longint'(cin);
        e.ovf = (st >= half) || (st < -half);
        e.tag = tag;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic rand_a();
        a_in_op  = 1'($urandom);
        a_in_a   = WA'($urandom);
        a_in_b   = WA'($urandom);
        a_in_cin = 1'($urandom);
        a_in_tag = TW'($urandom);
    endtask

    task automatic rand_b();
        b_in_op  = 1'($urandom);
        b_in_a   = WB'($urandom);
        b_in_b   = WB'($urandom);
        b_in_cin = 1'($urandom);
        b_in_tag = TW'($urandom);
    endtask

    // One clock: observe handshakes mid-cycle, score results, then advance.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
            if (a_first_out < 0) a_first_out = cyc;
            a_last_out = cyc;
            a_nout++;
            n_cmp++;
            assert (qa.size() > 0) else begin
                n_err++;
                $error("FAIL a_spurious: observed output with %0d pending, required >0 pending", qa.size());
            end
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_sum", 16'(a_out_sum), e.sum);
                chk("a_carry", 16'(a_out_carry), 16'(e.carry));
                chk("a_tag", 16'(a_out_tag), 16'(e.tag));
`ifdef PPA_OVF_FLAG_EN
                chk("a_ovf", 16'(a_out_ovf), 16'(e.ovf));
`endif
            end
        end
        if (a_in_valid === 1'b1 && a_in_ready === 1'b1) begin
            if (a_first_in < 0) a_first_in = cyc;
            a_nin++;
            qa.push_back(model(WA, a_in_op, 16'(a_in_a), 16'(a_in_b), a_in_cin, a_in_tag));
        end
        if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
            if (b_first_out < 0) b_first_out = cyc;
            b_nout++;
            n_cmp++;
            assert (qb.size() > 0) else begin
                n_err++;
                $error("FAIL b_spurious: observed output with %0d pending, required >0 pending", qb.size());
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_sum", 16'(b_out_sum), e.sum);
                chk("b_carry", 16'(b_out_carry), 16'(e.carry));
                chk("b_tag", 16'(b_out_tag), 16'(e.tag));
`ifdef PPA_OVF_FLAG_EN
                chk("b_ovf", 16'(b_out_ovf), 16'(e.ovf));
`endif
            end
        end
        if (b_in_valid === 1'b1 && b_in_ready === 1'b1) begin
            if (b_first_in < 0) b_first_in = cyc;
            b_nin++;
            qb.push_back(model(WB, b_in_op, 16'(b_in_a), 16'(b_in_b), b_in_cin, b_in_tag));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single op on the 8-bit instance: latency counted in rising edges
    // starting with the accepting edge, then the result fields.
    task automatic dir_a(input string nm, input logic op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [3:0] tag,
                         input logic [7:0] es, input logic ec);
        int lat;
        a_in_op = op; a_in_a = a; a_in_b = b; a_in_cin = cin; a_in_tag = tag;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, 16'(a_in_ready), 16'd1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (a_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 16'(lat), 16'd3);
        chk({nm, "_sum"}, 16'(a_out_sum), 16'(es));
        chk({nm, "_carry"}, 16'(a_out_carry), 16'(ec));
        chk({nm, "_tag"}, 16'(a_out_tag), 16'(tag));
`ifdef PPA_OVF_FLAG_EN
        a_last_ovf = a_out_ovf;
`endif
        @(posedge clk);
        #1;
        cyc += lat + 1;
    endtask

    initial begin
        int base_in, base_out, guard;
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        rand_a();
        rand_b();

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        chk("rst_out_valid", 16'(a_out_valid), 16'd0);
        chk("rst_in_ready", 16'(a_in_ready), 16'd1);
        chk("rst_out_sum", 16'(a_out_sum), 16'd0);
        chk("rst_out_carry", 16'(a_out_carry), 16'd0);
        chk("rst_out_tag", 16'(a_out_tag), 16'd0);
        chk("rst_b_out_valid", 16'(b_out_valid), 16'd0);
        chk("rst_b_in_ready", 16'(b_in_ready), 16'd1);

        // Directed arithmetic corners with exact latency
        dir_a("sub_5_3", PPA_SUB, 8'h05, 8'h03, 1'b1, 4'h1, 8'h02, 1'b1);
        dir_a("sub_3_5", PPA_SUB, 8'h03, 8'h05, 1'b1, 4'h2, 8'hFE, 1'b0);
        dir_a("add_ff_1", PPA_ADD, 8'hFF, 8'h01, 1'b0, 4'h3, 8'h00, 1'b1);
`ifdef PPA_OVF_FLAG_EN
        chk("ovf_ff_1", 16'(a_last_ovf), 16'd0);
`endif
        dir_a("add_7f_1", PPA_ADD, 8'h7F, 8'h01, 1'b0, 4'h4, 8'h80, 1'b0);
`ifdef PPA_OVF_FLAG_EN
        chk("ovf_7f_1", 16'(a_last_ovf), 16'd1);
`endif

        // Back-to-back stream on both instances, out_ready held high
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        a_nin = 0; a_nout = 0; a_first_in = -1; a_first_out = -1;
        b_nin = 0; b_nout = 0; b_first_in = -1; b_first_out = -1;
        for (int k = 0; k < 16; k++) begin
            rand_a(); rand_b();
            a_in_valid = 1'b1; b_in_valid = 1'b1;
            step();
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        chk("a_stream_accepted", 16'(a_nin), 16'd16);
        chk("b_stream_accepted", 16'(b_nin), 16'd16);
        repeat (10) step();
        chk("a_stream_results", 16'(a_nout), 16'd16);
        chk("b_stream_results", 16'(b_nout), 16'd16);
        chk("a_stream_latency", 16'(a_first_out - a_first_in), 16'd3);
        chk("b_stream_latency", 16'(b_first_out - b_first_in), 16'd5);
        chk("a_stream_rate", 16'(a_last_out - a_first_out), 16'd15);
        chk("a_stream_drained", 16'(qa.size()), 16'd0);
        chk("b_stream_drained", 16'(qb.size()), 16'd0);

        // Back-pressure: offer 5 with out_ready low, only 3 fit
        a_out_ready = 1'b0;
        base_in = a_nin; base_out = a_nout;
        for (int k = 0; k < 7; k++) begin
            rand_a();
            a_in_valid = (a_nin - base_in) < 5;
            step();
            if (k >= 3) begin
                chk("hold_out_valid", 16'(a_out_valid), 16'd1);
                chk("hold_sum", 16'(a_out_sum), qa[0].sum);
                chk("hold_tag", 16'(a_out_tag), 16'(qa[0].tag));
            end
        end
        chk("hold_accepted", 16'(a_nin - base_in), 16'd3);
        chk("hold_in_ready", 16'(a_in_ready), 16'd0);
        a_out_ready = 1'b1;
        #1;
        chk("release_in_ready", 16'(a_in_ready), 16'd1);
        guard = 0;
        while (((a_nin - base_in) < 5 || qa.size() > 0) && guard < 40) begin
            rand_a();
            a_in_valid = (a_nin - base_in) < 5;
            step();
            guard++;
        end
        a_in_valid = 1'b0;
        chk("hold_total_in", 16'(a_nin - base_in), 16'd5);
        chk("hold_total_out", 16'(a_nout - base_out), 16'd5);

        // Reset with three ops in flight
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_a();
            a_in_valid = 1'b1;
            step();
        end
        a_in_valid = 1'b0;
        chk("flight_valid", 16'(a_out_valid), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        qa.delete();
        chk("midrst_out_valid", 16'(a_out_valid), 16'd0);
        chk("midrst_in_ready", 16'(a_in_ready), 16'd1);
        chk("midrst_out_sum", 16'(a_out_sum), 16'd0);
        chk("midrst_out_tag", 16'(a_out_tag), 16'd0);
        a_out_ready = 1'b1;
        base_out = a_nout;
        repeat (10) step();
        chk("midrst_no_ghosts", 16'(a_nout - base_out), 16'd0);

        // Random valid/ready over 200 ops, scoreboard checks each result
        base_in = a_nin; base_out = a_nout;
        guard = 0;
        while (((a_nin - base_in) < 200 || qa.size() > 0) && guard < 3000) begin
            rand_a();
            a_in_valid  = ((a_nin - base_in) < 200) && ($urandom_range(0, 9) < 7);
            a_out_ready = 1'($urandom);
            step();
            guard++;
        end
        a_in_valid = 1'b0;
        chk("rand_accepted", 16'(a_nin - base_in), 16'd200);
        chk("rand_results", 16'(a_nout - base_out), 16'd200);
        chk("rand_drained", 16'(qa.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ppa_addsub_pipe.md
Name: ppa_addsub_pipe

Overview:
- Parametrised, pipelined parallel-prefix (Sklansky) adder/subtractor. Successor to the fixed 8-bit single-cycle subtractor used by unpack_s3.
- Adds generic width, add/sub mode, carry-in, configurable pipeline cut points, a valid/ready handshake and a pass-through tag.
- Serves as the shared arithmetic core for the unpack/pack and mod-q coefficient datapaths of the NTRU-HRSS KEM.

Parameters:
- W, 8, operand/result width in bits (≥2)
- PIPE_EVERY, 2, prefix levels per pipeline stage (≥1)
- TAG_W, 4, width of the sideband tag carried alongside each operation (≥1)

Ports:
- clk  in  1  clock; all flops rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_op  in  1  0 = add, 1 = subtract
- in_a  in  W  operand a
- in_b  in  W  operand b
- in_cin  in  1  carry-in (sub: 1 = plain a−b, 0 = a−b−1)
- in_tag  in  TAG_W  sideband, returned unchanged with result
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid & out_ready
- out_sum  out  W  result, modulo 2^W
- out_carry  out  1  carry out of MSB (sub: 1 = no borrow, i.e. a ≥ b+~cin unsigned)
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Arithmetic: b' = in_op ? ~in_b : in_b. {out_carry, out_sum} = in_a + b' + in_cin, full W+1 bits.
- Sub with cin=1 is bit-identical to the legacy subtractor: cin is folded into bit 0 as g0 = a0|b'0, p0 = ~(a0^b'0).
- Structure: L = clog2(W) Sklansky prefix levels. Stage 0 registers bitwise g/p, p-xor and tag. Each later stage registers after up to PIPE_EVERY levels; the final stage also registers sum and carry.
- Latency LAT = 1 + ceil(L/PIPE_EVERY) cycles from accept to out_valid (W=8, PIPE_EVERY=2: LAT=3). Capacity = LAT operations.
- Elastic pipeline, one valid bit per stage v[i]:
  - Stage i loads when its predecessor is valid and stage i is empty or advancing.
  - The last stage advances on out_ready.
  - Bubbles collapse.
  - in_ready = ~v[0] | adv[0]. The combinational path from out_ready to in_ready is permitted.
- Full throughput: one op per cycle while out_ready is held high.
- Full pipeline with out_ready=0: all stages hold; in_ready=0; out_sum/out_carry/out_tag stay stable while out_valid=1.
- Simultaneous out-handshake and in-handshake when full: both complete in the same cycle; no loss, no duplication.
- Order preserved: results emerge in acceptance order.
- Reset:
  - All v[i] cleared; out_valid=0; in_ready=1 in the first cycle after rst deasserts.
  - Data registers are not reset, but out_sum, out_carry and out_tag must read 0 while out_valid=0 after reset. Gate or reset the output stage.
  - Reset mid-operation discards all in-flight ops; none appear afterwards.
- W not a power of two: the prefix tree is built for 2^L and unused high positions are tied g=0, p=0.

Optional Feature:
- Macro PPA_OVF_FLAG_EN.
- When defined: adds output out_ovf (1 bit), the two's-complement signed overflow = carry into MSB ^ out_carry. It is pipelined with the result and follows the same reset and hold rules.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ppa_pkg holds:
  - constant function ppa_clog2
  - enum ppa_op_e {PPA_ADD=0, PPA_SUB=1}
  - function ppa_lat(W, PIPE_EVERY) used by the RTL and the bench
- Sub-module ppa_prefix_level: one combinational Sklansky level, parameters W and LEVEL, maps g/p vectors to g/p vectors. It is instantiated L times; registers are inserted between groups in ppa_addsub_pipe.

Test Plan:
- Sub, W=8, cin=1, a=0x05, b=0x03 → out_sum=0x02, out_carry=1. a=0x03, b=0x05 → 0xFE, carry=0. Both appear after exactly 3 cycles.
- Add, a=0xFF, b=0x01, cin=0 → 0x00, carry=1. a=0x7F, b=0x01 → 0x80, carry=0; out_ovf=1 when PPA_OVF_FLAG_EN is defined.
- Stream 16 random ops back-to-back with out_ready=1 → one result per cycle, in order, tags matching. Repeat with W=13, PIPE_EVERY=1 (LAT=5) against a reference model.
- Hold out_ready=0 while offering 5 ops → exactly 3 accepted, in_ready low from then on, outputs stable. Release → the remaining 2 are accepted, all 5 complete in order.
- Pulse rst for 1 cycle with 3 ops in flight → out_valid=0 next cycle, none of the 3 ever emitted, in_ready=1.
- Toggle out_ready randomly (50%) over 200 ops → no drop, no duplicate, ordering intact, checked by a scoreboard.
